// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h02000000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        read_write,
  input  logic [1:0]  access_size,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic [15:0] div, div_lat, bit_cnt;
  logic [7:0] shift;
  logic [2:0] idx;
  logic ovf, pop, tick, empty, full, sel, we;
  logic push_req, push_ok, ovf_set, ovf_clr, baud_we;
  logic [31:0] status;
  logic unused_ok;
  assign unused_ok = ^data_in[31:16];
  assign sel = address[31:4] == BASE_ADDR[31:4];
  assign we = sel && read_write;
  assign push_req = we && address[3:0] == 4'h0;
  assign ovf_clr = we && address[3:0] == 4'h4 && data_in[3];
  // access_size 3 is reserved and behaves as a word access
  assign baud_we = we && address[3:0] == 4'h8 && access_size[1];
  assign empty = count == '0;
  assign full = count == FULL_CNT;
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;
  assign tick = bit_cnt == 16'd0;
  assign status = {16'h0, 8'(count), 4'h0, ovf, full, empty, state != IDLE};
  assign data_out = (sel && !read_write) ? (address[3:0] == 4'h4 ? status :
                    address[3:0] == 4'h8 ? {16'h0, div} : 32'h0) : 32'h0;
  assign tx = state == START ? 1'b0 : state == DATA ? shift[idx] : 1'b1;
  assign irq = empty && state == IDLE;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        state_n = START;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick && idx == 3'd7) state_n = STOP;
      STOP: if (tick) begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
    endcase
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clock)
    if (push_ok) mem[wp] <= data_in[7:0];
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
    end else begin
      if (push_ok) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
      ovf <= ovf_set || (ovf && !ovf_clr);
      if (baud_we) div <= data_in[15:0] == 16'd0 ? 16'd1 : data_in[15:0];
    end
  end
  // divisor is latched per frame so BAUD writes only affect the next frame
  always_ff @(posedge clock) begin
    if (reset) begin
      shift <= '0;
      div_lat <= DEFAULT_DIV;
      bit_cnt <= '0;
      idx <= '0;
    end else if (pop) begin
      shift <= mem[rp];
      div_lat <= div;
      bit_cnt <= div - 16'd1;
      idx <= '0;
    end else if (state != IDLE) begin
      bit_cnt <= tick ? div_lat - 16'd1 : bit_cnt - 16'd1;
      if (tick && state == DATA) idx <= idx + 3'd1;
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for the memory-mapped UART transmitter
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h02000000;
  logic clock = 1'b0, reset = 1'b1;
  logic [31:0] address = '0, data_in = '0;
  logic read_write = 1'b0;
  logic [1:0] access_size = '0;
  logic [31:0] data_out;
  logic tx, irq;
  int checks = 0, failures = 0, tx_n = 0;
  typedef struct {string name; logic [31:0] d; logic irq;} exp_t;
  exp_t rq[$];
  exp_t re;
  logic txq[$];
  logic tb_bit;
  mmio_uart_tx dut (
    .clock(clock), .reset(reset), .address(address), .data_in(data_in),
    .read_write(read_write), .access_size(access_size),
    .data_out(data_out), .tx(tx), .irq(irq)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (!read_write && address[31:4] == BASE[31:4]) begin
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read addr=%h got=%h expected=none", address, data_out);
      end else begin
        re = rq.pop_front();
        if (data_out !== re.d) begin
          failures++;
          $display("FAIL %s data_out got=%h expected=%h", re.name, data_out, re.d);
        end
        checks++;
        if (irq !== re.irq) begin
          failures++;
          $display("FAIL %s irq got=%b expected=%b", re.name, irq, re.irq);
        end
      end
    end
    if (txq.size() > 0) begin
      tb_bit = txq.pop_front();
      tx_n++;
      checks++;
      if (tx !== tb_bit) begin
        failures++;
        $display("FAIL tx_sample_%0d got=%b expected=%b", tx_n, tx, tb_bit);
      end
    end
  end
  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [1:0] sz);
    address = BASE | 32'(off);
    data_in = d;
    read_write = 1'b1;
    access_size = sz;
    @(posedge clock);
    #1;
    address = '0;
    data_in = '0;
    read_write = 1'b0;
    access_size = '0;
  endtask
  task automatic rd(input string n, input logic [3:0] off, input logic [31:0] d, input logic e_irq);
    address = BASE | 32'(off);
    read_write = 1'b0;
    access_size = 2'd2;
    rq.push_back('{n, d, e_irq});
    @(posedge clock);
    #1;
    address = '0;
  endtask
  task automatic exp_tx(input logic b, input int n);
    repeat (n) txq.push_back(b);
  endtask
  task automatic exp_frame(input logic [7:0] b, input int dv);
    exp_tx(1'b0, dv);
    for (int i = 0; i < 8; i++) exp_tx(b[i], dv);
    exp_tx(1'b1, dv);
  endtask
  task automatic drain;
    for (int i = 0; i < 5000 && txq.size() > 0; i++) @(posedge clock);
    #1;
  endtask
  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_tx(1'b1, 3);
    rd("reset_status", 4'h4, 32'h00000002, 1'b1);
    rd("reset_baud", 4'h8, 32'h000001B2, 1'b1);
    rd("txdata_reads_zero", 4'h0, 32'h0, 1'b1);
    rd("unmapped_reads_zero", 4'hC, 32'h0, 1'b1);
    drain();
    wr(4'h8, 32'd4, 2'd2);
    wr(4'h0, 32'h123456A5, 2'd0);
    exp_tx(1'b1, 1);
    exp_tx(1'b0, 4);
    exp_tx(1'b1, 4); exp_tx(1'b0, 4); exp_tx(1'b1, 4); exp_tx(1'b0, 4);
    exp_tx(1'b0, 4); exp_tx(1'b1, 4); exp_tx(1'b0, 4); exp_tx(1'b1, 4);
    exp_tx(1'b1, 4);
    exp_tx(1'b1, 2);
    rd("queued_one", 4'h4, 32'h00000100, 1'b0);
    drain();
    rd("a5_done_status", 4'h4, 32'h00000002, 1'b1);
    wr(4'h8, 32'd2, 2'd2);
    for (int i = 0; i < 5; i++) wr(4'h0, 32'(8'h10 + i), 2'd2);
    rd("fifo_full", 4'h4, 32'h00000405, 1'b0);
    wr(4'h0, 32'h000000FF, 2'd0);
    rd("fifo_ovf", 4'h4, 32'h0000040D, 1'b0);
    wr(4'h4, 32'h00000008, 2'd2);
    rd("ovf_cleared", 4'h4, 32'h00000405, 1'b0);
    repeat (120) @(posedge clock);
    #1;
    rd("burst_done", 4'h4, 32'h00000002, 1'b1);
    wr(4'h8, 32'd3, 2'd2);
    wr(4'h0, 32'h0000003C, 2'd0);
    wr(4'h0, 32'h000000C3, 2'd0);
    exp_frame(8'h3C, 3);
    exp_frame(8'hC3, 3);
    exp_tx(1'b1, 3);
    drain();
    rd("two_frames_done", 4'h4, 32'h00000002, 1'b1);
    wr(4'h8, 32'd7, 2'd1);
    rd("baud_half_ignored", 4'h8, 32'd3, 1'b1);
    wr(4'h8, 32'd0, 2'd2);
    rd("baud_zero_is_one", 4'h8, 32'd1, 1'b1);
    wr(4'h8, 32'd5, 2'd3);
    rd("baud_size3_word", 4'h8, 32'd5, 1'b1);
    wr(4'h8, 32'd4, 2'd2);
    wr(4'h0, 32'h0, 2'd0);
    wr(4'h0, 32'h0, 2'd0);
    exp_tx(1'b0, 8);
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_tx(1'b1, 50);
    rd("post_reset_status", 4'h4, 32'h00000002, 1'b1);
    rd("post_reset_baud", 4'h8, 32'h000001B2, 1'b1);
    drain();
    checks++;
    if (rq.size() != 0 || txq.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got=%0d/%0d expected=0/0", rq.size(), txq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that responds to CPU data-memory accesses. It sits alongside dmemory on the same address/data/read_write/access_size bus.
- The top level routes an access here when the address falls in the block's window. Store data is taken from the rs2 data path; load data is returned into the writeback mux the same way dmemory's data_out is.
- Stored bytes queue in a small FIFO and are serialised 8N1, LSB first, on a single tx line.

Parameters:
- BASE_ADDR, 32'h02000000, base of the 16-byte register window; bits [3:0] must be zero.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of two, at least 2.
- DEFAULT_DIV, 16'd434, reset value of the baud divisor (clock cycles per bit).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  32  byte address from the CPU memory stage.
- data_in  input  32  store data.
- read_write  input  1  0 = read, 1 = write.
- access_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is reserved and treated as word.
- data_out  output  32  load data; combinational.
- tx  output  1  serial line; idles high.
- irq  output  1  high while the FIFO is empty and the transmitter is idle.

Behaviour:
- Select: sel = (address[31:4] == BASE_ADDR[31:4]). Register offset is address[3:0]. Offsets other than 0x0, 0x4 and 0x8 read as 0, and writes to them are ignored.
- 0x0 TXDATA (write only; reads return 0):
  - A write pushes data_in[7:0] for any access_size.
  - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and sticky ovf is set.
  - A push and a pop in the same cycle on a full FIFO is accepted; count stays at FIFO_DEPTH.
- 0x4 STATUS (read):
  - [0] busy (FSM not IDLE); [1] empty; [2] full; [3] ovf; [15:8] count; all other bits 0.
  - A write with data_in[3]=1 clears ovf. If a clear and an overflow happen in the same cycle, the overflow wins.
- 0x8 BAUD (read/write):
  - [15:0] div; upper bits read 0.
  - Written only when access_size is word. A written value of 0 is stored as 1.
- Write commit: the register or FIFO updates on the rising edge where sel and read_write=1.
- Read data: data_out = register value when sel and read_write=0, else 32'h0. Reads have no side effects.
- FSM states: IDLE, START, DATA, STOP.
- Bit timing: a bit counter counts div_latched-1 down to 0; each bit lasts exactly div_latched cycles. div_latched is captured from BAUD at each pop, so BAUD writes take effect from the next frame.
- IDLE:
  - tx=1.
  - At an edge with count>0: pop the head into the shift register, latch the divisor, go to START, and drive tx=0 from that edge.
  - Timing: a TXDATA write committing at edge k drives tx low after edge k+1.
- START: tx=0 for one bit time, then go to DATA with bit index 0.
- DATA: tx = shift[idx] for one bit time each, idx 0..7; after idx 7 go to STOP.
- STOP:
  - tx=1 for one bit time.
  - At its final cycle, if count>0, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Frame length: 10*div_latched cycles.
- FIFO: circular read/write pointers that wrap modulo FIFO_DEPTH; count runs 0..FIFO_DEPTH.
- Reset:
  - Values: state IDLE, tx=1, irq=1, FIFO empty, pointers 0, ovf=0, div=DEFAULT_DIV, data_out=0 when not selected.
  - Reset asserted mid-frame aborts the frame: tx is high after that edge and queued bytes are discarded.

Test Plan:
- Reset, then read STATUS at 0x02000004 -> data_out = 32'h00000002 (empty), tx=1, irq=1, BAUD reads 32'h000001B2.
- Write BAUD=4 (word), then byte-store 0xA5 to 0x02000000 at edge k -> tx low from edge k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high; busy falls after 40 cycles and irq returns to 1.
- With div=2, store 5 bytes back-to-back -> the first is popped, the next 4 fill the FIFO (STATUS count=4, full=1, ovf=0); a sixth store before any pop sets ovf=1; writing 0x8 to STATUS clears it.
- Two queued bytes with div=3 -> the second START begins the cycle after the first STOP ends (no idle gap); total 60 cycles low-to-idle.
- Halfword write of 0x0007 to BAUD -> ignored (BAUD unchanged); word write of 0 -> BAUD reads 1.
- Assert reset during the DATA state of a frame -> tx=1 on the next cycle, STATUS = 32'h00000002, nothing transmitted afterwards.
